// File: rtl/axi_lite_wr_rd_checker.sv
// axi_lite_wr_rd_checker: AXI4-Lite master that writes a pattern to each slave register,
// reads it back and counts mismatches and bad responses.
module axi_lite_wr_rd_checker #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
   parameter int C_NUM_REGS = 4,
   parameter int C_ADDR_STRIDE = 4,
   parameter int C_TIMEOUT = 1024
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic                            start,
   input  logic [1:0]                      mode,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   seed,
   output logic                            busy,
   output logic                            done,
   output logic                            pass,
   output logic [15:0]                     err_count,
   output logic                            err_resp,
   output logic                            timeout,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   first_err_addr,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);
   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam logic [DW-1:0] TAPS = (DW == 64) ? DW'(64'hD800000000000000) : DW'(32'h80200003);
   typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, NEXT, DONE} state_t;
   state_t state_q, state_d;
   logic [8:0] i_q, i_d;
   logic [AW-1:0] addr_q, addr_d, first_q, first_d;
   logic [DW-1:0] pat_q, pat_d, pat_p0, pat_nx;
   logic [1:0] mode_q, mode_d, err_inc;
   logic busy_q, busy_d, done_q, done_d, eresp_q, eresp_d, tmo_q, tmo_d, rsp_bad, clr;
   logic awv_q, awv_d, wv_q, wv_d, br_q, br_d, arv_q, arv_d, rr_q, rr_d;
   logic [15:0] err_q, err_d;
   logic [16:0] err_sum;
   logic [31:0] wd_q, wd_d;
   assign pat_p0 = (mode == 2'd1 || (mode == 2'd2 && seed == '0)) ? DW'(1) : seed;
   assign pat_nx = mode_q == 2'd0 ? pat_q + DW'(1) :
                   mode_q == 2'd1 ? {pat_q[DW-2:0], pat_q[DW-1]} :
                   mode_q == 2'd2 ? (pat_q >> 1) ^ (pat_q[0] ? TAPS : '0) : ~pat_q;
   always_comb begin
      state_d = state_q;
      i_d = i_q;
      addr_d = addr_q;
      pat_d = pat_q;
      mode_d = mode_q;
      busy_d = busy_q;
      done_d = done_q;
      eresp_d = eresp_q;
      tmo_d = tmo_q;
      first_d = first_q;
      awv_d = awv_q;
      wv_d = wv_q;
      br_d = br_q;
      arv_d = arv_q;
      rr_d = rr_q;
      err_inc = 2'd0;
      rsp_bad = 1'b0;
      clr = 1'b0;
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d = WR;
            mode_d = mode;
            pat_d = pat_p0;
            addr_d = C_BASE_ADDR;
            i_d = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
            eresp_d = 1'b0;
            tmo_d = 1'b0;
            first_d = '0;
            clr = 1'b1;
            awv_d = 1'b1;
            wv_d = 1'b1;
         end
         WR: begin
            awv_d = awv_q & ~M_AXI_AWREADY;
            wv_d = wv_q & ~M_AXI_WREADY;
            if (!awv_d && !wv_d) begin
               br_d = 1'b1;
               state_d = WR_RESP;
            end
         end
         WR_RESP: if (M_AXI_BVALID) begin
            rsp_bad = M_AXI_BRESP != 2'b00;
            err_inc = {1'b0, rsp_bad};
            br_d = 1'b0;
            arv_d = 1'b1;
            state_d = RD_ADDR;
         end
         RD_ADDR: if (M_AXI_ARREADY) begin
            arv_d = 1'b0;
            rr_d = 1'b1;
            state_d = RD_DATA;
         end
         RD_DATA: if (M_AXI_RVALID) begin
            rsp_bad = M_AXI_RRESP != 2'b00;
            err_inc = {1'b0, rsp_bad} + {1'b0, M_AXI_RDATA != pat_q};
            rr_d = 1'b0;
            state_d = NEXT;
         end
         NEXT: if (i_q == 9'(C_NUM_REGS - 1)) begin
            state_d = DONE;
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            i_d = i_q + 9'd1;
            addr_d = addr_q + AW'(C_ADDR_STRIDE);
            pat_d = pat_nx;
            awv_d = 1'b1;
            wv_d = 1'b1;
            state_d = WR;
         end
         default: state_d = IDLE;
      endcase
      eresp_d = eresp_d | rsp_bad;
      if (err_inc != 2'd0 && err_q == 16'd0) first_d = addr_q;
      err_sum = clr ? 17'd0 : {1'b0, err_q} + 17'(err_inc);
      err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
      // watchdog only flags; handshakes stay pending so the bus is never violated
      wd_d = state_d != state_q ? 32'd0 : wd_q + 32'd1;
      if (state_q inside {WR, WR_RESP, RD_ADDR, RD_DATA} && state_d == state_q && wd_q == 32'(C_TIMEOUT - 1))
         tmo_d = 1'b1;
   end
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q <= IDLE;
         i_q <= '0;
         addr_q <= '0;
         pat_q <= '0;
         mode_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         eresp_q <= 1'b0;
         tmo_q <= 1'b0;
         first_q <= '0;
         err_q <= '0;
         wd_q <= '0;
         awv_q <= 1'b0;
         wv_q <= 1'b0;
         br_q <= 1'b0;
         arv_q <= 1'b0;
         rr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q <= i_d;
         addr_q <= addr_d;
         pat_q <= pat_d;
         mode_q <= mode_d;
         busy_q <= busy_d;
         done_q <= done_d;
         eresp_q <= eresp_d;
         tmo_q <= tmo_d;
         first_q <= first_d;
         err_q <= err_d;
         wd_q <= wd_d;
         awv_q <= awv_d;
         wv_q <= wv_d;
         br_q <= br_d;
         arv_q <= arv_d;
         rr_q <= rr_d;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign pass = done_q && err_q == 16'd0 && !tmo_q;
   assign err_count = err_q;
   assign err_resp = eresp_q;
   assign timeout = tmo_q;
   assign first_err_addr = first_q;
   assign M_AXI_AWADDR = addr_q;
   assign M_AXI_ARADDR = addr_q;
   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;
   assign M_AXI_AWVALID = awv_q;
   assign M_AXI_WDATA = pat_q;
   assign M_AXI_WSTRB = '1;
   assign M_AXI_WVALID = wv_q;
   assign M_AXI_BREADY = br_q;
   assign M_AXI_ARVALID = arv_q;
   assign M_AXI_RREADY = rr_q;
endmodule

// File: doc/axi_lite_wr_rd_checker.md
Name: axi_lite_wr_rd_checker

Overview:
- Synthesizable AXI4-Lite master that runs a self-checking write/read-back sweep over a block of slave registers. For each register it writes a generated pattern, reads it back, and compares the two.
- Parametrised in address/data width, register count, stride and pattern mode. Reports pass/fail, an error count and the first failing address.
- Sits beside a custom AXI-Lite slave IP as an on-chip smoke/regression engine, driven from a control register or a board-level start pin.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; 32 or 64 only.
- C_BASE_ADDR, 32'h0, address of the first register.
- C_NUM_REGS, 4, registers per sweep; range 1..256.
- C_ADDR_STRIDE, 4, byte increment between registers.
- C_TIMEOUT, 1024, watchdog cycles allowed per wait state.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  synchronous active-low reset.
- start  in  1  pulse that begins a sweep.
- mode  in  2  pattern select, sampled on start.
- seed  in  DW  pattern seed, sampled on start.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held until the next accepted start.
- pass  out  1  valid only while done=1; 1 = no errors.
- err_count  out  16  mismatches plus bad responses; saturates at 16'hFFFF.
- err_resp  out  1  sticky; a BRESP or RRESP other than OKAY was seen.
- timeout  out  1  sticky; the watchdog expired.
- first_err_addr  out  AW  address of the first error.
- M_AXI_AWADDR out AW; M_AXI_AWPROT out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out DW; M_AXI_WSTRB out DW/8; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out AW; M_AXI_ARPROT out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in DW; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:
- Clocking/reset: one clock ACLK. Reset is ARESETN, synchronous and active-low.
- Reset values: every output is 0, including all VALID/READY signals, AWPROT/ARPROT, err_count and first_err_addr.
- Reset mid-sweep: state goes to IDLE and all VALIDs drop at the same edge; no transaction is completed.
- Fixed outputs: AWPROT = ARPROT = 3'b000; WSTRB is all ones.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, NEXT, DONE.
- IDLE/DONE + start=1:
  - Register mode and seed; clear index i, err_count, err_resp, timeout and first_err_addr.
  - Clear done and set busy.
  - Go to WR; AWVALID and WVALID are both high from the next cycle.
- start while busy is ignored.
- WR:
  - AWADDR = C_BASE_ADDR + i*C_ADDR_STRIDE, truncated to AW bits (address wrap-around permitted).
  - AWVALID and WVALID each drop on the edge that completes their own handshake. They may complete in either order or together.
  - Once both have completed: BREADY=1, go to WR_RESP.
- WR_RESP: on BVALID, BRESP != 2'b00 counts as an error and sets err_resp. Then ARVALID=1, go to RD_ADDR.
- RD_ADDR: ARADDR equals the AWADDR just written. On ARREADY, drop ARVALID, set RREADY=1, go to RD_DATA.
- RD_DATA, on RVALID:
  - Drop RREADY.
  - RRESP != OKAY counts as an error and sets err_resp.
  - RDATA != written pattern counts as an error.
  - A bad RRESP plus a data mismatch on the same beat counts as 2 errors.
  - Go to NEXT.
- NEXT: i+1; return to WR if i < C_NUM_REGS, else go to DONE.
- DONE: busy=0, done=1, pass = (err_count==0 && !timeout).
- first_err_addr latches the register address of the first error only.
- Pattern P(i) by mode:
  - 0: seed + i (mod 2^DW).
  - 1: walking one, 1 << (i mod DW).
  - 2: LFSR. P(0)=seed, or 1 if seed is 0. Advance once per register, Galois shift right; taps 32'h80200003 for DW=32, 64'hD800000000000000 for DW=64.
  - 3: alternating, seed for even i and ~seed for odd i.
- Watchdog:
  - Counter resets on every state change.
  - After C_TIMEOUT cycles in the same wait state (WR, WR_RESP, RD_ADDR, RD_DATA), set timeout.
  - The FSM keeps waiting; VALIDs are never withdrawn before their handshake.
- Throughput: with zero-wait slave readies, one register costs 5 cycles (WR, WR_RESP, RD_ADDR, RD_DATA, NEXT).

Test Plan:
- Memory-like slave, always ready; mode=0, seed=32'h0101FFFF, C_NUM_REGS=4, base 0 -> writes 0101FFFF/01020000/01020001/01020002 to 0x0/0x4/0x8/0xC, read-back matches, done=1, pass=1, err_count=0, sweep takes 20 cycles.
- Slave with AWREADY delayed 3 cycles and WREADY 0 cycles, then swapped -> each VALID drops on its own handshake, sweep passes.
- Slave forcing bit 0 of register 0x8 to 0; mode=3, seed=32'hDEAD0011 -> err_count=1, first_err_addr=0x8, pass=0.
- Slave returns SLVERR on every BRESP with correct read data -> err_count=4, err_resp=1, pass=0.
- ARREADY tied low, C_TIMEOUT=16 -> timeout=1 after 16 cycles in RD_ADDR, ARVALID stays high, busy=1; release ARREADY -> sweep completes with done=1, pass=0.
- ARESETN low for 1 cycle mid-RD_DATA, then start with mode=2, seed=0 -> all outputs 0 after reset; LFSR pattern begins at 1, pass=1; a start asserted while busy has no effect.
